mem_reader_seq: RTL and testbench

MEM_READER_SEQ -- requirements
Module: mem_reader_seq

---
 rtl/mem_reader_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_reader_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_reader_seq.sv
// mem_reader_seq
//   Sequencer that either streams a fixed-length byte load into an SRAM, or
//   walks an element index through the address generator, reads the SRAM and
//   presents the results on a ready/valid output stream through a two-entry
//   skid FIFO.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start, i_mode, i_depth  job request (sampled in IDLE only)
//   o_busy, o_done            job in progress / one-cycle completion pulse
//   o_counter, o_mode         element index and job mode to the address generator
//   i_zero                    address generator: current element is padding
//   o_mem_cen_n, o_mem_wen_n  SRAM chip enable / write enable (active-low)
//   o_mem_wdata, i_mem_rdata  SRAM write data / read data (one cycle latency)
//   i_in_valid, i_in_data     load-mode byte stream (no backpressure)
//   o_out_valid/data/last     read-mode output stream
//   i_out_ready               downstream ready
module mem_reader_seq #(
    parameter int unsigned LOAD_LEN  = 2048,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_mode,
    input  logic [1:0]  i_depth,
    output logic        o_busy,
    output logic        o_done,
    output logic [10:0] o_counter,
    output logic [1:0]  o_mode,
    input  logic        i_zero,
    output logic        o_mem_cen_n,
    output logic        o_mem_wen_n,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_out_valid,
    output logic [7:0]  o_out_data,
    output logic        o_out_last,
    input  logic        i_out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [10:0] LOAD_LAST = 11'(LOAD_LEN - 1);

    state_t      state;
    logic [10:0] n_last;
    logic [10:0] chan;
    logic [10:0] n_elems;
    logic [10:0] n_last_next;

    // Pending read stage: one entry in flight between issue and FIFO push.
    logic        pend_valid;
    logic        pend_zero;
    logic        pend_last;

    // Two-entry FIFO; entry 0 is the head and drives the output directly.
    logic [1:0]  fifo_count;
    logic [7:0]  e0_data, e1_data;
    logic        e0_last, e1_last;

    logic        pop;
    logic        push;
    logic [7:0]  push_data;
    logic [2:0]  occ;
    logic        issue;
    logic        issue_last;

    // Element count of the requested read job, captured with i_start.
    always_comb begin
        case (i_depth)
            2'd0:    chan = 11'd8;
            2'd1:    chan = 11'd16;
            default: chan = 11'd32;
        endcase
        n_elems     = (i_mode == 2'd2) ? (chan << 4) : (chan << 2);
        n_last_next = n_elems - 11'd1;
    end

    assign o_busy      = (state != S_IDLE);
    assign o_out_valid = (fifo_count != 2'd0);
    assign o_out_data  = e0_data;
    assign o_out_last  = e0_last;

    assign pop       = o_out_valid & i_out_ready;
    assign push      = pend_valid;
    assign push_data = pend_zero ? 8'h00 : i_mem_rdata;

    // Occupancy next cycle (FIFO plus the read already in flight) must leave
    // room for the element issued now.
    assign occ        = {1'b0, fifo_count} + {2'b00, pend_valid} - {2'b00, pop};
    assign issue      = (state == S_READ) && (occ < 3'(BUF_DEPTH));
    assign issue_last = issue && (o_counter == n_last);

    always_comb begin
        o_mem_cen_n = 1'b1;
        o_mem_wen_n = 1'b1;
        o_mem_wdata = '0;
        if (state == S_LOAD && i_in_valid) begin
            o_mem_cen_n = 1'b0;
            o_mem_wen_n = 1'b0;
            o_mem_wdata = i_in_data;
        end else if (issue && !i_zero) begin
            o_mem_cen_n = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            o_counter <= '0;
            o_mode    <= '0;
            o_done    <= 1'b0;
            n_last    <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_counter <= '0;
                        o_mode    <= i_mode;
                        n_last    <= n_last_next;
                        case (i_mode)
                            2'd0:    state <= S_LOAD;
                            2'd3: begin
                                state  <= S_DONE;
                                o_done <= 1'b1;
                            end
                            default: state <= S_READ;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (i_in_valid) begin
                        if (o_counter == LOAD_LAST) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            o_counter <= o_counter + 11'd1;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        if (issue_last) begin
                            state <= S_DRAIN;
                        end else begin
                            o_counter <= o_counter + 11'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && e0_last) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fifo_count <= '0;
            e0_data    <= '0;
            e0_last    <= 1'b0;
            e1_data    <= '0;
            e1_last    <= 1'b0;
            pend_valid <= 1'b0;
            pend_zero  <= 1'b0;
            pend_last  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        e0_data <= push_data;
                        e0_last <= pend_last;
                    end else begin
                        e1_data <= push_data;
                        e1_last <= pend_last;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    // Head is cleared when the FIFO empties so no stale last flag lingers.
                    if (fifo_count == 2'd1) begin
                        e0_data <= '0;
                        e0_last <= 1'b0;
                    end else begin
                        e0_data <= e1_data;
                        e0_last <= e1_last;
                    end
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        e0_data <= push_data;
                        e0_last <= pend_last;
                    end else begin
                        e0_data <= e1_data;
                        e0_last <= e1_last;
                        e1_data <= push_data;
                        e1_last <= pend_last;
                    end
                end
                default: ;
            endcase
            pend_valid <= issue;
            pend_zero  <= issue & i_zero;
            pend_last  <= issue_last;
        end
    end

endmodule

// File: tb/tb_mem_reader_seq.sv
module tb_mem_reader_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [1:0]  depth;
    logic        busy, done;
    logic [10:0] counter;
    logic [1:0]  o_mode;
    logic        zero;
    logic        cen_n, wen_n;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        ready;

    logic        zero_en;
    logic        rand_ready;

    always #5 clk = ~clk;

    mem_reader_seq #(.LOAD_LEN(2048), .BUF_DEPTH(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_mode      (mode),
        .i_depth     (depth),
        .o_busy      (busy),
        .o_done      (done),
        .o_counter   (counter),
        .o_mode      (o_mode),
        .i_zero      (zero),
        .o_mem_cen_n (cen_n),
        .o_mem_wen_n (wen_n),
        .o_mem_wdata (wdata),
        .i_mem_rdata (rdata),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .i_out_ready (ready)
    );

    // Address generator stand-in: padding on elements 0..3 when enabled.
    assign zero = zero_en && (counter < 11'd4);

    // SRAM model addressed directly by the element counter.
    logic [7:0] mem [0:2047];
    always @(posedge clk) begin
        if (!cen_n && !wen_n) mem[counter] <= wdata;
        if (!cen_n && wen_n)  rdata <= mem[counter];
    end

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int out_cnt = 0;
    int acc_cnt = 0;

    typedef struct { logic [7:0] data; logic last; } exp_t;
    typedef struct { logic [10:0] addr; logic [7:0] data; } wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: all DUT observation happens on the falling edge.
    logic       held = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (!cen_n) acc_cnt++;
            if (!cen_n && !wen_n) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write_addr", counter, w.addr);
                    check("write_data", wdata, w.data);
                end
            end
            if (!cen_n && wen_n) check("read_on_zero", zero, 0);
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_data);
                check("stall_last", out_last, held_last);
            end
            if (out_valid && ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                end
            end
            held      = out_valid && !ready;
            held_data = out_data;
            held_last = out_last;
        end else begin
            held = 1'b0;
        end
    end

    // Downstream ready: random while rand_ready is set, otherwise held high.
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_counter", counter, 0);
        check("rst_mode", o_mode, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_cen_n", cen_n, 1);
        check("rst_wen_n", wen_n, 1);
        check("rst_wdata", wdata, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic issue_start(input logic [1:0] m, input logic [1:0] d);
        @(posedge clk);
        #1 start = 1'b1; mode = m; depth = d;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        check({name, "_done_seen"}, done_cnt, d0 + 1);
        repeat (3) @(posedge clk);
        check({name, "_done_once"}, done_cnt, d0 + 1);
        check({name, "_idle"}, busy, 0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic load_job();
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 2048; k++) mem[k] = 8'h00;
        issue_start(2'd0, 2'd0);
        for (int k = 0; k < 2048; k++) begin
            if (k == 500 || k == 1200 || k == 1900) begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
                @(negedge clk);
                check("gap_cen_n", cen_n, 1);
                check("gap_counter_hold", counter, k);
                @(posedge clk);
                #1;
            end
            wr_q.push_back('{addr: 11'(k), data: 8'(k)});
            in_valid = 1'b1;
            in_data  = 8'(k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("load_done_after_last", done, 1);
        wait_done(d0, 10, "load");
        check("load_writes_left", wr_q.size(), 0);
    endtask

    task automatic read_job(input logic [1:0] m, input logic [1:0] d, input int n,
                            input logic zen, input logic rr, input string name);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < n; k++)
            exp_q.push_back('{data: (zen && k < 4) ? 8'h00 : 8'(k), last: (k == n - 1)});
        zero_en    = zen;
        rand_ready = rr;
        issue_start(m, d);
        @(negedge clk);
        check({name, "_busy"}, busy, 1);
        check({name, "_valid_c1"}, out_valid, 0);
        @(negedge clk);
        check({name, "_valid_c2_early"}, out_valid, 0);
        @(negedge clk);
        check({name, "_first_valid"}, out_valid, 1);
        if (!rr) begin
            for (int k = 1; k < n; k++) begin
                @(negedge clk);
                check({name, "_stream_gap"}, out_valid, 1);
            end
            check({name, "_last_flag"}, out_last, 1);
            @(negedge clk);
            check({name, "_done_next"}, done, 1);
        end else begin
            // A start request mid-job must be ignored.
            repeat (5) @(posedge clk);
            #1 start = 1'b1; mode = 2'd3;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done(d0, 2000, name);
        rand_ready = 1'b0;
        zero_en    = 1'b0;
    endtask

    task automatic abort_job();
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 256; k++)
            exp_q.push_back('{data: 8'(k), last: (k == 255)});
        issue_start(2'd2, 2'd1);
        for (int i = 0; i < 300 && counter != 11'd50; i++) @(negedge clk);
        check("abort_reached_50", counter, 50);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_counter", counter, 0);
        check("abort_cen_n", cen_n, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        check("abort_no_done", done_cnt, d0);
        check("abort_no_output", out_valid, 0);
    endtask

    task automatic reserved_job();
        int d0, a0, o0;
        d0 = done_cnt;
        a0 = acc_cnt;
        o0 = out_cnt;
        issue_start(2'd3, 2'd0);
        @(negedge clk);
        check("mode3_done", done, 1);
        @(negedge clk);
        check("mode3_done_pulse", done, 0);
        check("mode3_idle", busy, 0);
        repeat (2) @(posedge clk);
        check("mode3_done_count", done_cnt, d0 + 1);
        check("mode3_no_access", acc_cnt, a0);
        check("mode3_no_output", out_cnt, o0);
    endtask

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        mode       = 2'd0;
        depth      = 2'd0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        zero_en    = 1'b0;
        rand_ready = 1'b0;

        apply_reset();
        load_job();

        // Load stream left active during a read job must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        read_job(2'd1, 2'd0, 32, 1'b0, 1'b0, "disp8");
        in_valid = 1'b0;

        read_job(2'd2, 2'd0, 128, 1'b1, 1'b0, "conv8_zero");
        read_job(2'd1, 2'd3, 128, 1'b0, 1'b1, "disp32_bp");

        abort_job();
        read_job(2'd1, 2'd0, 32, 1'b0, 1'b0, "disp8_after_abort");

        reserved_job();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
